// File: rtl/spi_master_param.sv
// SPI master: one DATA_WIDTH-bit full-duplex word per transfer, per-transfer CPOL/CPHA/bit order.
// SCLK half period is HALF_PERIOD system clocks; START/BUSY/DONE handshake, ERR on a bad slave index.
module spi_master_param #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_SLAVES  = 3,
  parameter int HALF_PERIOD = 2,
  localparam int SEL_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_cpol,
  input  logic                  i_cpha,
  input  logic                  i_lsb_first,
  input  logic [SEL_W-1:0]      i_slave_sel,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic                  i_miso,
  output logic                  o_sclk,
  output logic                  o_mosi,
  output logic [NUM_SLAVES-1:0] o_ss_n,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  // state   | meaning
  // S_IDLE  | waiting for START; SCLK tracks CPOL; DONE/ERR pulses are visible here
  // S_SETUP | slave selected, first MOSI bit driven, lasts one half period
  // S_XFER  | SCLK toggles every half period for 2*DATA_WIDTH edges
  // S_HOLD  | SCLK back at idle level, select still asserted for one half period

  localparam int CNT_W  = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0]  HP_LOAD    = CNT_W'(HALF_PERIOD - 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE  = EDGE_W'(2 * DATA_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD} state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [EDGE_W-1:0]     r_edge;
  logic [DATA_WIDTH-1:0] r_tx;
  logic [DATA_WIDTH-1:0] r_rx;
  logic                  r_cpha;
  logic                  r_lsb;

  logic [EDGE_W-1:0]     w_edge_num;
  logic                  w_leading;
  logic                  w_first;
  logic                  w_last;
  logic                  w_sample;
  logic                  w_shift;
  logic                  w_sel_ok;
  logic                  w_first_bit;
  logic [NUM_SLAVES-1:0] w_ss_dec;
  logic [DATA_WIDTH-1:0] w_rx_next;
  logic [DATA_WIDTH-1:0] w_tx_next;
  logic                  w_mosi_next;

  assign w_edge_num  = r_edge + EDGE_W'(1);
  assign w_leading   = w_edge_num[0];
  assign w_first     = (w_edge_num == EDGE_W'(1));
  assign w_last      = (w_edge_num == LAST_EDGE);
  // CPHA=0 samples on leading edges, CPHA=1 on trailing; the other edge shifts
  assign w_sample    = w_leading ^ r_cpha;
  assign w_shift     = !w_sample && !w_first && !w_last;

  assign w_sel_ok    = (32'(i_slave_sel) < 32'(NUM_SLAVES));
  assign w_first_bit = i_lsb_first ? i_tx_data[0] : i_tx_data[DATA_WIDTH-1];
  assign w_ss_dec    = ~(NUM_SLAVES'(1) << i_slave_sel);

  assign w_rx_next   = r_lsb ? {i_miso, r_rx[DATA_WIDTH-1:1]} : {r_rx[DATA_WIDTH-2:0], i_miso};
  assign w_tx_next   = r_lsb ? (r_tx >> 1) : (r_tx << 1);
  assign w_mosi_next = r_lsb ? r_tx[1] : r_tx[DATA_WIDTH-2];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_edge    <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_cpha    <= 1'b0;
      r_lsb     <= 1'b0;
      o_sclk    <= 1'b0;
      o_mosi    <= 1'b0;
      o_ss_n    <= '1;
      o_rx_data <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          o_sclk <= i_cpol;
          o_mosi <= 1'b0;
          if (i_start) begin
            if (w_sel_ok) begin
              r_state <= S_SETUP;
              r_cnt   <= HP_LOAD;
              r_edge  <= '0;
              r_tx    <= i_tx_data;
              r_rx    <= '0;
              r_cpha  <= i_cpha;
              r_lsb   <= i_lsb_first;
              o_mosi  <= w_first_bit;
              o_ss_n  <= w_ss_dec;
              o_busy  <= 1'b1;
            end else begin
              o_err <= 1'b1;
            end
          end
        end
        S_SETUP, S_XFER: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_cnt   <= HP_LOAD;
            r_edge  <= w_edge_num;
            o_sclk  <= ~o_sclk;
            r_state <= w_last ? S_HOLD : S_XFER;
            if (w_sample) r_rx <= w_rx_next;
            if (w_shift) begin
              r_tx   <= w_tx_next;
              o_mosi <= w_mosi_next;
            end
          end
        end
        S_HOLD: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_state   <= S_IDLE;
            o_ss_n    <= '1;
            o_busy    <= 1'b0;
            o_done    <= 1'b1;
            o_mosi    <= 1'b0;
            o_rx_data <= r_rx;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: a behavioural SPI slave follows SCLK on the pins and reports what it
// received; directed and random transfers on a W=8/H=2 instance, back-to-back on a W=16/H=1 instance.
module tb_spi_master_param;

  logic        clk;
  logic        rst_n;
  logic        start, cpol, cpha, lsb;
  logic [1:0]  sel;
  logic [15:0] tx;
  logic        miso;
  logic        use16;

  logic        start8, start16;
  logic        sclk8, mosi8, busy8, done8, err8;
  logic [2:0]  ss8;
  logic [7:0]  rx8;
  logic        sclk16, mosi16, busy16, done16, err16;
  logic [2:0]  ss16;
  logic [15:0] rx16;

  logic        m_sclk, m_mosi, m_busy, m_done, m_err;
  logic [2:0]  m_ss_n;
  logic [31:0] m_rx;

  int n_assert = 0;
  int n_fail   = 0;

  assign start8  = start & ~use16;
  assign start16 = start & use16;
  assign m_sclk  = use16 ? sclk16 : sclk8;
  assign m_mosi  = use16 ? mosi16 : mosi8;
  assign m_busy  = use16 ? busy16 : busy8;
  assign m_done  = use16 ? done16 : done8;
  assign m_err   = use16 ? err16  : err8;
  assign m_ss_n  = use16 ? ss16   : ss8;
  assign m_rx    = use16 ? {16'h0, rx16} : {24'h0, rx8};

  spi_master_param #(.DATA_WIDTH(8), .NUM_SLAVES(3), .HALF_PERIOD(2)) u_dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start8), .i_cpol(cpol), .i_cpha(cpha),
    .i_lsb_first(lsb), .i_slave_sel(sel), .i_tx_data(tx[7:0]), .i_miso(miso),
    .o_sclk(sclk8), .o_mosi(mosi8), .o_ss_n(ss8), .o_rx_data(rx8),
    .o_busy(busy8), .o_done(done8), .o_err(err8));

  spi_master_param #(.DATA_WIDTH(16), .NUM_SLAVES(3), .HALF_PERIOD(1)) u_dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start16), .i_cpol(cpol), .i_cpha(cpha),
    .i_lsb_first(lsb), .i_slave_sel(sel), .i_tx_data(tx), .i_miso(miso),
    .o_sclk(sclk16), .o_mosi(mosi16), .o_ss_n(ss16), .o_rx_data(rx16),
    .o_busy(busy16), .o_done(done16), .o_err(err16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // slave model configuration and observations
  int          sl_w = 8;
  bit          sl_cpha = 1'b0;
  bit          sl_lsb = 1'b0;
  logic [31:0] sl_reply = '0;
  logic [31:0] sl_rx = '0;
  int          sl_k = 0;
  int          sl_nrx = 0;
  int          sl_high_run = 0;
  bit          sl_act, sl_prev_act = 1'b0, sl_prev_sclk = 1'b0, sl_leading;
  logic [31:0] rx_q[$];
  int          edge_q[$];
  int          gap_q[$];

  function automatic int bit_pos(input int j);
    return sl_lsb ? j : sl_w - 1 - j;
  endfunction

  always @(negedge clk) begin
    sl_act = (m_ss_n != 3'b111);
    if (sl_act && !sl_prev_act) begin
      gap_q.push_back(sl_high_run);
      sl_k   = 0;
      sl_nrx = 0;
      sl_rx  = '0;
      miso   = sl_reply[bit_pos(0)];
    end else if (sl_act && (m_sclk != sl_prev_sclk)) begin
      sl_k++;
      sl_leading = (sl_k % 2) == 1;
      if (sl_leading != sl_cpha && sl_nrx < sl_w) begin
        sl_rx[bit_pos(sl_nrx)] = m_mosi;
        sl_nrx++;
      end
      if (!sl_cpha && !sl_leading && (sl_k / 2) < sl_w) miso = sl_reply[bit_pos(sl_k / 2)];
      if (sl_cpha && sl_leading) miso = sl_reply[bit_pos((sl_k - 1) / 2)];
    end else if (!sl_act && sl_prev_act) begin
      rx_q.push_back(sl_rx);
      edge_q.push_back(sl_k);
    end
    if (sl_act) sl_high_run = 0;
    else sl_high_run++;
    sl_prev_act  = sl_act;
    sl_prev_sclk = m_sclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One transfer end to end; optional START pulse while busy at cycle ignore_at (0 = none).
  task automatic run_xfer(input bit u16, input bit pol, input bit pha, input bit lsbf,
                          input logic [1:0] s, input logic [31:0] txw, input logic [31:0] rep,
                          input int ignore_at);
    int w, h, n, done_n, exp_n;
    bit busy_ok, ss_ok, err_seen;
    logic [2:0] exp_ss;
    w = u16 ? 16 : 8;
    h = u16 ? 1 : 2;
    exp_n  = 1 + (2 * w + 1) * h;
    exp_ss = ~(3'b001 << s);
    @(negedge clk);
    use16 = u16; cpol = pol; cpha = pha; lsb = lsbf; sel = s; tx = txw[15:0];
    sl_w = w; sl_cpha = pha; sl_lsb = lsbf; sl_reply = rep;
    rx_q.delete(); edge_q.delete();
    @(negedge clk);
    chk("sclk_idle_before", m_sclk, pol);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1; done_n = 0; busy_ok = 1; ss_ok = 1; err_seen = 0;
    while (done_n == 0 && n <= exp_n + 20) begin
      if (m_err) err_seen = 1;
      if (m_done) done_n = n;
      else begin
        if (m_busy !== 1'b1) busy_ok = 0;
        if (m_ss_n !== exp_ss) ss_ok = 0;
        if (n == ignore_at) begin start = 1'b1; sel = 2'd0; tx = ~tx; end
        if (n == ignore_at + 1) start = 1'b0;
        @(negedge clk);
        n++;
      end
    end
    chk("done_cycle", done_n, exp_n);
    chk("busy_during", busy_ok, 1);
    chk("ss_during", ss_ok, 1);
    chk("ss_at_done", m_ss_n, 3'b111);
    chk("busy_at_done", m_busy, 0);
    chk("rx_data", m_rx, rep);
    chk("sclk_idle_after", m_sclk, pol);
    chk("no_err", err_seen, 0);
    #1;
    chk("slave_rx", (rx_q.size() > 0) ? rx_q[0] : 32'hFFFF_FFFF, txw);
    chk("sclk_edges", (edge_q.size() > 0) ? edge_q[0] : -1, 2 * w);
    @(negedge clk);
    chk("done_one_cycle", m_done, 0);
    if (ignore_at > 0) begin
      repeat (3) @(negedge clk);
      chk("ignored_start_idle", m_busy, 0);
      chk("ignored_start_ss", m_ss_n, 3'b111);
    end
  endtask

  initial begin
    int n;
    bit done_seen;
    logic [31:0] rtx, rrep;
    start = 0; cpol = 0; cpha = 0; lsb = 0; sel = 0; tx = '0; miso = 0; use16 = 0;
    rst_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_sclk", m_sclk, 0);
    chk("rst_mosi", m_mosi, 0);
    chk("rst_ss", m_ss_n, 3'b111);
    chk("rst_rx", m_rx, 0);
    chk("rst_busy_done_err", {m_busy, m_done, m_err}, 3'b000);
    rst_n = 1;
    cpol = 1;
    repeat (2) @(negedge clk);
    chk("idle_sclk_follows_cpol", m_sclk, 1);
    cpol = 0;

    // reset in the middle of a mode-0 transfer, after SCLK edge 5
    @(negedge clk);
    sel = 2'd1; tx = 16'h00A5; sl_w = 8; sl_cpha = 0; sl_lsb = 0; sl_reply = 32'h3C;
    start = 1;
    @(negedge clk);
    start = 0;
    n = 0;
    while (sl_k < 5 && n < 200) begin @(negedge clk); #1; n++; end
    chk("reached_edge5", sl_k, 5);
    chk("sclk_high_at_edge5", m_sclk, 1);
    #2 rst_n = 0;
    #1;
    chk("abort_ss", m_ss_n, 3'b111);
    chk("abort_sclk", m_sclk, 0);
    chk("abort_busy", m_busy, 0);
    @(negedge clk);
    rst_n = 1;
    done_seen = 0;
    repeat (40) begin @(negedge clk); if (m_done) done_seen = 1; end
    chk("abort_no_done", done_seen, 0);
    chk("abort_rx_kept", m_rx, 0);

    // mode 0 MSB first, mode 3 LSB first
    run_xfer(0, 0, 0, 0, 2'd1, 32'hA5, 32'h3C, 0);
    run_xfer(0, 1, 1, 1, 2'd2, 32'h81, 32'h01, 0);

    // reject an out-of-range slave, then a START while busy
    @(negedge clk);
    use16 = 0; sel = 2'd3; start = 1;
    chk("err_before", m_err, 0);
    @(negedge clk);
    start = 0;
    chk("err_pulse", m_err, 1);
    chk("reject_ss", m_ss_n, 3'b111);
    chk("reject_busy", m_busy, 0);
    @(negedge clk);
    chk("err_one_cycle", m_err, 0);
    run_xfer(0, 0, 0, 0, 2'd0, 32'h5E, 32'hC7, 10);

    for (int i = 0; i < 6; i++) begin
      rtx  = $urandom & 32'hFF;
      rrep = $urandom & 32'hFF;
      run_xfer(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               2'($urandom_range(0, 2)), rtx, rrep, 0);
    end

    // back-to-back on the W=16, H=1 instance, mode 1
    @(negedge clk);
    use16 = 1; cpol = 0; cpha = 1; lsb = 0; sel = 2'd2; tx = 16'hBEEF;
    sl_w = 16; sl_cpha = 1; sl_lsb = 0; sl_reply = 32'h5A5A;
    rx_q.delete(); edge_q.delete(); gap_q.delete();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    tx = 16'h1234;
    n = 1;
    while (!m_done && n < 60) begin @(negedge clk); n++; end
    chk("b2b_first_done", n, 34);
    chk("b2b_first_rx", m_rx, 32'h5A5A);
    #1 sl_reply = 32'hC3C3;
    @(negedge clk);
    start = 0;
    chk("b2b_second_busy", m_busy, 1);
    n = 1;
    while (!m_done && n < 60) begin @(negedge clk); n++; end
    chk("b2b_second_done", n, 34);
    chk("b2b_second_rx", m_rx, 32'hC3C3);
    #1;
    chk("b2b_slave_rx0", (rx_q.size() > 0) ? rx_q[0] : 32'hFFFF_FFFF, 32'hBEEF);
    chk("b2b_slave_rx1", (rx_q.size() > 1) ? rx_q[1] : 32'hFFFF_FFFF, 32'h1234);
    chk("b2b_ss_gap", (gap_q.size() > 1) ? gap_q[gap_q.size() - 1] : -1, 1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master_param.md
# spi_master_param

Parametrised, fully synchronous SPI master. It serialises one DATA_WIDTH-bit word per transfer to one of NUM_SLAVES slaves and captures the full-duplex reply. CPOL, CPHA and bit order are selectable per transfer, and SCLK is generated from the system clock by a programmable divider. It sits between the host-side control logic and the SPI pins, and uses a START/BUSY/DONE handshake.

## Interface
Parameters:
- DATA_WIDTH, default 8: word length in bits; legal range 2..32.
- NUM_SLAVES, default 3: number of slave-select lines; legal range 1..8.
- HALF_PERIOD, default 2: system-clock cycles per SCLK half period; legal range 1..255.
- SEL_W, default max(1, clog2(NUM_SLAVES)): width of SLAVE_SEL; derived, not overridden.

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  transfer request; sampled every cycle.
- CPOL  in  1  SCLK idle level; latched at accept.
- CPHA  in  1  clock phase; latched at accept.
- LSB_FIRST  in  1  0 selects MSB first, 1 selects LSB first; latched at accept.
- SLAVE_SEL  in  SEL_W  target slave index; latched at accept.
- TX_DATA  in  DATA_WIDTH  word to send; latched at accept.
- MISO  in  1  serial data from the slave.
- SCLK  out  1  SPI clock.
- MOSI  out  1  serial data to the slave.
- SS_N  out  NUM_SLAVES  active-low selects; at most one low at any time.
- RX_DATA  out  DATA_WIDTH  last received word.
- BUSY  out  1  high from the cycle after accept through the cycle before DONE.
- DONE  out  1  one-cycle pulse when the transfer ends.
- ERR  out  1  one-cycle pulse when a request is rejected.

## Operation
- **States:** IDLE → SETUP → XFER → HOLD → IDLE.
- **Accept:** START=1 with BUSY=0 and SLAVE_SEL<NUM_SLAVES.
  - CPOL, CPHA, LSB_FIRST, SLAVE_SEL and TX_DATA are latched into a shift register.
  - The FSM moves to SETUP.
- **Reject:** START=1 with BUSY=0 and SLAVE_SEL≥NUM_SLAVES.
  - ERR=1 on the next cycle; the FSM stays in IDLE and no output other than ERR changes.
- **START while BUSY=1:** ignored. Requests are not queued and ERR is not raised.
- **IDLE:**
  - SCLK follows registered CPOL every cycle.
  - SS_N is all ones and MOSI=0.
- **SETUP** (HALF_PERIOD cycles):
  - SS_N[sel]=0 and SCLK=latched CPOL.
  - MOSI presents the first bit: TX[W-1] when MSB first, TX[0] when LSB first.
- **XFER:** SCLK toggles every HALF_PERIOD cycles, for exactly 2·DATA_WIDTH edges.
  - Odd-numbered edges are leading edges; even-numbered edges are trailing edges.
  - CPHA=0: sample MISO on leading edges; shift MOSI to the next bit on trailing edges. There is no shift on the final edge.
  - CPHA=1: shift MOSI on leading edges, except the first edge, which keeps the SETUP bit; sample MISO on trailing edges.
  - "Sample" means capturing the MISO value present on the same CLK edge at which SCLK toggles.
- **Receive ordering:**
  - MSB first: the first sampled bit lands in RX[W-1], filling downward.
  - LSB first: the first sampled bit lands in RX[0], filling upward.
- **HOLD** (HALF_PERIOD cycles): SCLK=CPOL and SS_N is still asserted.
- **End of HOLD** (single cycle):
  - SS_N all ones, BUSY=0, DONE=1.
  - RX_DATA is loaded with the assembled word. RX_DATA changes only at this point.
- **Reset values** (asynchronous, RST_N low), including mid-transfer:
  - SCLK=0, MOSI=0, SS_N all ones, RX_DATA=0, BUSY=0, DONE=0, ERR=0, FSM=IDLE.
  - A transfer aborted by reset produces no DONE, and RX_DATA is not updated.

## Timing
- Call the accept cycle t0.
- **Transfer timeline:**
  - t0+1: BUSY=1, SS_N asserted, first MOSI bit valid.
  - SCLK edge k (k=1..2W) occurs at t0+1+k·H, where H=HALF_PERIOD.
  - DONE, BUSY=0 and SS_N deassert all occur at t0+1+(2W+1)·H.
  - Example: W=8, H=2 gives DONE at t0+35.
- **Back-to-back:**
  - START high in the DONE cycle is accepted.
  - SS_N is then high for exactly one cycle before the next SETUP.
- **SCLK duty and glitches:** SCLK high and low phases are each exactly H cycles. SCLK has no glitches; it is a register output.
- **ERR timing:** a reject at t0 gives ERR at t0+1 only.

## Test plan
- **Mode 0, MSB first** (W=8, H=2, NUM_SLAVES=3):
  - Stimulus: TX=0xA5, SLAVE_SEL=1, slave model returns 0x3C.
  - Required response: SS_N=3'b101 during the transfer; slave captures 0xA5; RX_DATA=0x3C; DONE at t0+35; exactly 16 SCLK edges.
- **Mode 3, LSB first:**
  - Stimulus: TX=0x81, slave returns 0x01.
  - Required response: SCLK idles high; MOSI order is 1,0,0,0,0,0,0,1; RX_DATA=0x01.
- **Reject and ignore:**
  - Stimulus: SLAVE_SEL=3 with NUM_SLAVES=3, then a START pulse while BUSY=1.
  - Required response: ERR pulses one cycle for the first; SS_N stays 3'b111 for the first; the second START is ignored and the first transfer finishes unchanged.
- **Reset mid-transfer:**
  - Stimulus: RST_N low after edge 5.
  - Required response: SS_N=all ones, SCLK=0 and BUSY=0 immediately, with no DONE; RX_DATA keeps 0.
- **Back-to-back, W=16, H=1, mode 1:**
  - Stimulus: START held high across the DONE cycle, TX=0xBEEF then 0x1234.
  - Required response: slave receives 0xBEEF then 0x1234; SS_N high for exactly one cycle between the two transfers.
